// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter multiplexing NUM_CH level-req / pulse-ready memory masters
// onto one shared memory port, with an optional response timeout.
module mem_arbiter_rr #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        i_ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] i_ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_wdata,
  input  logic [NUM_CH-1:0]        i_ch_we,
  input  logic [NUM_CH*3-1:0]      i_ch_mode,
  output logic [NUM_CH-1:0]        o_ch_ready,
  output logic [NUM_CH-1:0]        o_ch_err,
  output logic [DATA_W-1:0]        o_ch_rdata,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  output logic                     o_mem_we,
  output logic [2:0]               o_mem_mode,
  output logic                     o_mem_req,
  input  logic [DATA_W-1:0]        i_mem_rdata,
  input  logic                     i_mem_ready,
  output logic [NUM_CH-1:0]        o_grant,
  output logic                     o_busy
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   g;
  logic [CNT_W-1:0]   cnt;

  logic [ADDR_W-1:0]  ch_addr  [NUM_CH];
  logic [DATA_W-1:0]  ch_wdata [NUM_CH];
  logic [2:0]         ch_mode  [NUM_CH];

  logic [PTR_W-1:0]   hi_pick_c;
  logic [PTR_W-1:0]   lo_pick_c;
  logic               hi_any_c;
  logic [PTR_W-1:0]   pick_c;
  logic               timeout_hit_c;
  logic [PTR_W-1:0]   ptr_next_c;
  logic [NUM_CH-1:0]  g_onehot_c;

  // Unpack the flat per-channel buses into indexable arrays.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_addr[k]  = i_ch_addr[k*ADDR_W +: ADDR_W];
    assign ch_wdata[k] = i_ch_wdata[k*DATA_W +: DATA_W];
    assign ch_mode[k]  = i_ch_mode[k*3 +: 3];
  end

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_pick_c = '0;
    lo_pick_c = '0;
    hi_any_c  = 1'b0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (i_ch_req[j]) begin
        lo_pick_c = PTR_W'(j);
        if (j >= int'(ptr)) begin
          hi_pick_c = PTR_W'(j);
          hi_any_c  = 1'b1;
        end
      end
    end
    pick_c = hi_any_c ? hi_pick_c : lo_pick_c;
  end

  assign timeout_hit_c = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
  assign ptr_next_c    = (g == PTR_W'(NUM_CH - 1)) ? '0 : g + 1'b1;
  assign g_onehot_c    = NUM_CH'(1) << g;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      g           <= '0;
      cnt         <= '0;
      o_ch_ready  <= '0;
      o_ch_err    <= '0;
      o_ch_rdata  <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_we    <= 1'b0;
      o_mem_mode  <= '0;
      o_mem_req   <= 1'b0;
      o_grant     <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_ch_ready <= '0;
      o_ch_err   <= '0;
      case (state)
        S_IDLE: begin
          if (|i_ch_req) begin
            g           <= pick_c;
            o_mem_addr  <= ch_addr[pick_c];
            o_mem_wdata <= ch_wdata[pick_c];
            o_mem_we    <= i_ch_we[pick_c];
            o_mem_mode  <= ch_mode[pick_c];
            o_mem_req   <= 1'b1;
            o_grant     <= NUM_CH'(1) << pick_c;
            o_busy      <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          cnt <= cnt + 1'b1;
          // A ready on the timeout cycle still counts as a normal completion.
          if (i_mem_ready) begin
            o_ch_rdata <= i_mem_rdata;
            o_ch_ready <= g_onehot_c;
            o_mem_req  <= 1'b0;
            state      <= S_RESP;
          end else if (timeout_hit_c) begin
            o_ch_rdata <= '0;
            o_ch_ready <= g_onehot_c;
            o_ch_err   <= g_onehot_c;
            o_mem_req  <= 1'b0;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          ptr     <= ptr_next_c;
          cnt     <= '0;
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
